lcd_fb_blitter: RTL and testbench

- Frame buffer and sprite blitter directly upstream of the KS0108-style 128x64 LCD driver.
- Owns the 1024-byte display RAM. Serves the driver's 10-bit read address combinationally.
- Game logic uses it to clear the screen, OR sprites in, or erase them at arbitrary pixel positions, including vertical sub-page offsets.

---
 rtl/lcd_fb_blitter.sv | 179 +++++++++++++++++
 tb/tb_lcd_fb_blitter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_blitter.sv
// 128x64 LCD frame buffer with clear / sprite OR-blit / sprite erase engine.
// Optional sprite collision flag hit_o is enabled by defining LCD_FB_COLLIDE_EN.
module lcd_fb_blitter #(
    parameter int SPR_W     = 16,
    parameter int SPR_PAGES = 2,
    parameter int SPR_ID_W  = 2,
    localparam int SA_W     = SPR_ID_W + $clog2(SPR_PAGES) + $clog2(SPR_W)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [9:0]          rd_addr_i,
    output logic [7:0]          rd_data_o,
    input  logic                start_i,
    input  logic [1:0]          op_i,
    input  logic [7:0]          fill_i,
    input  logic [SPR_ID_W-1:0] spr_id_i,
    input  logic [6:0]          pos_x_i,
    input  logic [5:0]          pos_y_i,
    output logic [SA_W-1:0]     spr_addr_o,
    input  logic [7:0]          spr_data_i,
`ifdef LCD_FB_COLLIDE_EN
    output logic                hit_o,
`endif
    output logic                busy_o,
    output logic                done_o
);
    localparam int KW = $clog2(SPR_W);
    localparam int IW = SA_W - SPR_ID_W;
    localparam int NB = SPR_W * SPR_PAGES;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_BLIT  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_FETCH, S_LO, S_HI, S_DONE} state_t;

    state_t              state_q;
    logic                busy_q, done_q;
    logic [SA_W-1:0]     spr_addr_q;
    logic [9:0]          cnt_q;
    logic [1:0]          op_q;
    logic [7:0]          fill_q, byte_q;
    logic [SPR_ID_W-1:0] id_q;
    logic [6:0]          x_q;
    logic [5:0]          y_q;

    logic [7:0] mem [1024];

    // cnt_q doubles as the CLR address and the sprite byte index {p,k}
    logic [9:0]  pidx, kidx, cnt_nxt;
    logic [7:0]  col;
    logic [3:0]  pg_lo, pg;
    logic [7:0]  bsrc, sb, old, newb;
    logic [15:0] sh;
    logic [9:0]  waddr;
    logic        in_apply, clip, apply;
    logic        we_d;
    logic [9:0]  wa_d;
    logic [7:0]  wd_d;

    always_comb begin
        pidx     = cnt_q >> KW;
        kidx     = cnt_q & 10'(SPR_W - 1);
        cnt_nxt  = cnt_q + 10'd1;
        col      = {1'b0, x_q} + kidx[7:0];
        pg_lo    = {1'b0, y_q[5:3]} + pidx[3:0];
        in_apply = (state_q == S_LO) || (state_q == S_HI);
        pg       = (state_q == S_HI) ? pg_lo + 4'd1 : pg_lo;
        bsrc     = (state_q == S_HI) ? byte_q : spr_data_i;
        sh       = {8'h00, bsrc} << y_q[2:0];
        sb       = (state_q == S_HI) ? sh[15:8] : sh[7:0];
        waddr    = {col[6], pg[2:0], col[5:0]};
        old      = mem[waddr];
        clip     = col[7] | pg[3];
        apply    = in_apply && !clip;
        newb     = (op_q == OP_BLIT) ? (old | sb) : (old & ~sb);
        we_d     = 1'b0;
        wa_d     = waddr;
        wd_d     = newb;
        if (state_q == S_CLR) begin
            we_d = 1'b1;
            wa_d = cnt_q;
            wd_d = fill_q;
        end else if (apply) begin
            we_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && we_d)
            mem[wa_d] <= wd_d;
    end

    assign rd_data_o = mem[rd_addr_i];

`ifdef LCD_FB_COLLIDE_EN
    logic hit_q;
    assign hit_o = hit_q;
    always_ff @(posedge clk) begin
        if (!rstn)
            hit_q <= 1'b0;
        else if (state_q == S_IDLE && start_i)
            hit_q <= 1'b0;
        else if (apply && op_q == OP_BLIT && (old & sb) != 8'h00)
            hit_q <= 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            spr_addr_q <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            fill_q     <= '0;
            byte_q     <= '0;
            id_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start_i) begin
                    op_q       <= op_i;
                    fill_q     <= fill_i;
                    id_q       <= spr_id_i;
                    x_q        <= pos_x_i;
                    y_q        <= pos_y_i;
                    cnt_q      <= '0;
                    spr_addr_q <= SA_W'(spr_id_i) << IW;
                    if (op_i == OP_CLEAR) begin
                        state_q <= S_CLR;
                        busy_q  <= 1'b1;
                    end else if (op_i == OP_BLIT || op_i == OP_ERASE) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_CLR: begin
                    cnt_q <= cnt_nxt;
                    if (cnt_q == 10'd1023) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_FETCH: state_q <= S_LO;
                S_LO, S_HI: begin
                    byte_q <= spr_data_i;
                    if (state_q == S_LO && y_q[2:0] != 3'd0) begin
                        state_q <= S_HI;
                    end else if (cnt_q == 10'(NB - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        state_q    <= S_FETCH;
                        cnt_q      <= cnt_nxt;
                        spr_addr_q <= (SA_W'(id_q) << IW) | SA_W'(cnt_nxt);
                    end
                    if (state_q == S_HI)
                        byte_q <= byte_q;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign spr_addr_o = spr_addr_q;
endmodule

// File: tb/tb_lcd_fb_blitter.sv
// Directed bench for lcd_fb_blitter; covers the collision flag when LCD_FB_COLLIDE_EN is defined.
module tb_lcd_fb_blitter;
    logic       clk = 1'b0;
    logic       rstn;
    logic [9:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic       start_i;
    logic [1:0] op_i;
    logic [7:0] fill_i;
    logic [1:0] spr_id_i;
    logic [6:0] pos_x_i;
    logic [5:0] pos_y_i;
    logic [6:0] spr_addr_o;
    logic [7:0] spr_data_i;
    logic       busy_o, done_o;
`ifdef LCD_FB_COLLIDE_EN
    logic       hit_o;
`endif

    int checks = 0;
    int errors = 0;
    logic hit_at_done;

    always #5 clk = ~clk;

    lcd_fb_blitter dut (
        .clk(clk), .rstn(rstn), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .start_i(start_i), .op_i(op_i), .fill_i(fill_i), .spr_id_i(spr_id_i),
        .pos_x_i(pos_x_i), .pos_y_i(pos_y_i), .spr_addr_o(spr_addr_o),
        .spr_data_i(spr_data_i),
`ifdef LCD_FB_COLLIDE_EN
        .hit_o(hit_o),
`endif
        .busy_o(busy_o), .done_o(done_o)
    );

    // Registered sprite ROM: id0 byte i = i+1, id1 all 0xFF, id2 0x81 then zeros, id3 0x3C
    logic [7:0] rom [128];
    initial begin
        for (int i = 0; i < 32; i++) begin
            rom[i]      = 8'(i + 1);
            rom[32 + i] = 8'hFF;
            rom[64 + i] = (i == 0) ? 8'h81 : 8'h00;
            rom[96 + i] = 8'h3C;
        end
    end
    always @(posedge clk) spr_data_i <= rom[spr_addr_o];

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] fill, input logic [1:0] id,
                           input logic [6:0] x, input logic [5:0] y, input int pulse_at,
                           output int nbusy, output int ndone);
        nbusy = 0;
        ndone = 0;
        hit_at_done = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; fill_i = fill; spr_id_i = id; pos_x_i = x; pos_y_i = y;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            start_i = (c == pulse_at);
            if (busy_o) nbusy++;
            if (done_o) begin
                ndone++;
`ifdef LCD_FB_COLLIDE_EN
                hit_at_done = hit_o;
`endif
                break;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done_o) ndone++;
            if (busy_o) nbusy++;
        end
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        rd_addr_i = 10'(a);
        #1;
        d = rd_data_o;
    endtask

    task automatic count_ne(input logic [7:0] v, output int bad);
        logic [7:0] d;
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            rd(a, d);
            if (d !== v) bad++;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; start_i = 1'b0; op_i = 2'b00; fill_i = 8'h00; spr_id_i = 2'd0;
        pos_x_i = 7'd0; pos_y_i = 6'd0; rd_addr_i = 10'd0;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", busy_o); errors++; end
        checks++; if (done_o !== 1'b0) begin $display("FAIL reset_done got %b exp 0", done_o); errors++; end
        checks++; if (spr_addr_o !== 7'd0) begin $display("FAIL reset_spr_addr got %0d exp 0", spr_addr_o); errors++; end
        rstn = 1'b1;
    endtask

    task automatic test_clear;
        int nb, nd, bad;
        run_cmd(2'b00, 8'hA5, 2'd0, 7'd0, 6'd0, -1, nb, nd);
        checks++; if (nb !== 1024) begin $display("FAIL clear_busy got %0d exp 1024", nb); errors++; end
        checks++; if (nd !== 1) begin $display("FAIL clear_done got %0d exp 1", nd); errors++; end
        count_ne(8'hA5, bad);
        checks++; if (bad !== 0) begin $display("FAIL clear_sweep got %0d bad bytes exp 0", bad); errors++; end
    endtask

    task automatic test_blit_aligned;
        int nb, nd, bad;
        logic [7:0] d;
        run_cmd(2'b00, 8'h00, 2'd0, 7'd0, 6'd0, -1, nb, nd);
        run_cmd(2'b01, 8'h00, 2'd1, 7'd0, 6'd0, -1, nb, nd);
        checks++; if (nb !== 64) begin $display("FAIL blit0_busy got %0d exp 64", nb); errors++; end
        checks++; if (nd !== 1) begin $display("FAIL blit0_done got %0d exp 1", nd); errors++; end
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            rd(a, d); if (d !== 8'hFF) bad++;
            rd(64 + a, d); if (d !== 8'hFF) bad++;
        end
        checks++; if (bad !== 0) begin $display("FAIL blit0_bytes got %0d bad exp 0", bad); errors++; end
        rd(16, d);
        checks++; if (d !== 8'h00) begin $display("FAIL blit0_addr16 got %h exp 00", d); errors++; end
        rd(80, d);
        checks++; if (d !== 8'h00) begin $display("FAIL blit0_addr80 got %h exp 00", d); errors++; end
    endtask

    task automatic test_blit_shift;
        int nb, nd;
        logic [7:0] d;
        run_cmd(2'b00, 8'h00, 2'd0, 7'd0, 6'd0, -1, nb, nd);
        run_cmd(2'b01, 8'h00, 2'd2, 7'd5, 6'd3, -1, nb, nd);
        checks++; if (nb !== 96) begin $display("FAIL shift_busy got %0d exp 96", nb); errors++; end
        rd(5, d);
        checks++; if (d !== 8'h08) begin $display("FAIL shift_addr5 got %h exp 08", d); errors++; end
        rd(69, d);
        checks++; if (d !== 8'h04) begin $display("FAIL shift_addr69 got %h exp 04", d); errors++; end
        rd(6, d);
        checks++; if (d !== 8'h00) begin $display("FAIL shift_addr6 got %h exp 00", d); errors++; end
    endtask

    task automatic test_clip;
        int nb, nd, bad;
        logic [7:0] d;
        run_cmd(2'b00, 8'h00, 2'd0, 7'd0, 6'd0, -1, nb, nd);
        // y=60 is page 7, shift 4: only page 7 columns 120..127 land on screen
        run_cmd(2'b01, 8'h00, 2'd1, 7'd120, 6'd60, -1, nb, nd);
        checks++; if (nb !== 96) begin $display("FAIL clip_busy got %0d exp 96", nb); errors++; end
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            rd(a, d);
            if (a >= 1016) begin
                if (d !== 8'hF0) bad++;
            end else if (d !== 8'h00) bad++;
        end
        checks++; if (bad !== 0) begin $display("FAIL clip_sweep got %0d bad exp 0", bad); errors++; end
    endtask

    task automatic test_back_to_back;
        int nb, nd, bad;
        logic [7:0] d;
        run_cmd(2'b00, 8'h00, 2'd0, 7'd0, 6'd0, -1, nb, nd);
        run_cmd(2'b01, 8'h00, 2'd0, 7'd60, 6'd13, 30, nb, nd);
        checks++; if (nd !== 1) begin $display("FAIL b2b_blit_done got %0d exp 1", nd); errors++; end
        checks++; if (nb !== 96) begin $display("FAIL b2b_blit_busy got %0d exp 96", nb); errors++; end
        rd(124, d);
        checks++; if (d !== 8'h20) begin $display("FAIL b2b_addr124 got %h exp 20", d); errors++; end
        run_cmd(2'b10, 8'h00, 2'd0, 7'd60, 6'd13, 40, nb, nd);
        checks++; if (nd !== 1) begin $display("FAIL b2b_erase_done got %0d exp 1", nd); errors++; end
        count_ne(8'h00, bad);
        checks++; if (bad !== 0) begin $display("FAIL b2b_erase_sweep got %0d bad exp 0", bad); errors++; end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; spr_id_i = 2'd3; pos_x_i = 7'd10; pos_y_i = 6'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin $display("FAIL mid_busy_before got %b exp 1", busy_o); errors++; end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin $display("FAIL mid_rst_busy got %b exp 0", busy_o); errors++; end
        checks++; if (done_o !== 1'b0) begin $display("FAIL mid_rst_done got %b exp 0", done_o); errors++; end
        checks++; if (spr_addr_o !== 7'd0) begin $display("FAIL mid_rst_spr_addr got %0d exp 0", spr_addr_o); errors++; end
        rstn = 1'b1;
        @(negedge clk);
    endtask

`ifdef LCD_FB_COLLIDE_EN
    task automatic test_collide;
        int nb, nd;
        run_cmd(2'b00, 8'h00, 2'd0, 7'd0, 6'd0, -1, nb, nd);
        run_cmd(2'b01, 8'h00, 2'd1, 7'd0, 6'd0, -1, nb, nd);
        checks++; if (hit_at_done !== 1'b0) begin $display("FAIL hit_clean got %b exp 0", hit_at_done); errors++; end
        run_cmd(2'b01, 8'h00, 2'd1, 7'd0, 6'd0, -1, nb, nd);
        checks++; if (hit_at_done !== 1'b1) begin $display("FAIL hit_overlap got %b exp 1", hit_at_done); errors++; end
    endtask
`endif

    initial begin
        test_reset;
        test_clear;
        test_blit_aligned;
        test_blit_shift;
        test_clip;
        test_back_to_back;
        test_reset_mid;
`ifdef LCD_FB_COLLIDE_EN
        test_collide;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
